// File: rtl/rotate_sched_if.sv
// Request/grant/result bundle shared by the two rotate clients and the scheduler.
// The master side is the client side. The slave side is the scheduler.
interface rotate_sched_if #(
    parameter int N  = 8,
    parameter int AW = 3
);
    logic          req0;
    logic [N-1:0]  a0;
    logic [AW-1:0] amt0;
    logic          lr0;
    logic          req1;
    logic [N-1:0]  a1;
    logic [AW-1:0] amt1;
    logic          lr1;
    logic          gnt0;
    logic          gnt1;
    logic          busy;
    logic          done;
    logic          id;
    logic [N-1:0]  y;

    modport master (
        output req0, a0, amt0, lr0, req1, a1, amt1, lr1,
        input  gnt0, gnt1, busy, done, id, y
    );

    modport slave (
        input  req0, a0, amt0, lr0, req1, a1, amt1, lr1,
        output gnt0, gnt1, busy, done, id, y
    );
endinterface

// File: rtl/rotate_sched.sv
// Round-robin scheduler for two clients sharing one rotate datapath.
// A left rotate is run as reverse, then rotate-right, then reverse.
module rotate_sched #(
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    rotate_sched_if.slave bus
);
    typedef enum logic {IDLE, ROT} state_t;

    state_t        state_q;
    logic          ptr_q, dir_q, own_q;
    logic          gnt0_q, gnt1_q, busy_q, done_q, id_q;
    logic [N-1:0]  r_q, y_q;
    logic [AW-1:0] cnt_q;

    logic          win_d, lr_d;
    logic [N-1:0]  r_d;
    logic [AW-1:0] amt_d;

    function automatic logic [N-1:0] rev(input logic [N-1:0] x);
        logic [N-1:0] res;
        for (int i = 0; i < N; i++) res[N-1-i] = x[i];
        return res;
    endfunction

    // The pointer only matters when both clients are requesting.
    always_comb begin
        win_d = (bus.req0 && bus.req1) ? ptr_q : bus.req1;
        lr_d  = win_d ? bus.lr1 : bus.lr0;
        amt_d = win_d ? bus.amt1 : bus.amt0;
        r_d   = win_d ? bus.a1 : bus.a0;
        if (lr_d) r_d = rev(r_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            dir_q   <= 1'b0;
            own_q   <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            id_q    <= 1'b0;
            r_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
        end else begin
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        r_q     <= r_d;
                        cnt_q   <= amt_d;
                        dir_q   <= lr_d;
                        own_q   <= win_d;
                        gnt0_q  <= ~win_d;
                        gnt1_q  <= win_d;
                        ptr_q   <= ~win_d;
                        busy_q  <= 1'b1;
                        state_q <= ROT;
                    end
                end
                ROT: begin
                    if (cnt_q != '0) begin
                        r_q   <= {r_q[0], r_q[N-1:1]};
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        y_q     <= dir_q ? rev(r_q) : r_q;
                        id_q    <= own_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt0 = gnt0_q;
    assign bus.gnt1 = gnt1_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.id   = id_q;
    assign bus.y    = y_q;
endmodule

// File: tb/tb_rotate_sched.sv
// Scoreboard bench for rotate_sched: directed requests push expected results,
// and a negedge monitor checks grants, latency, busy length and results.
module tb_rotate_sched;
    logic clk = 1'b0;
    logic reset = 1'b1;

    rotate_sched_if #(.N(8), .AW(3)) bus ();
    rotate_sched #(.N(8), .AW(3)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic       id;
        logic [7:0] y;
        int         amt;
    } exp_t;

    exp_t q[$];
    int   ntests = 0;
    int   nfail = 0;
    int   cyc = 0;
    int   gnt_cyc = 0;
    int   busy_cnt = 0;
    int   last_done = -1;
    bit   b2b_chk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        ntests++;
        nfail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: at most one operation is in flight, so q[0] is the one granted.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!reset) begin
            if (bus.gnt0 || bus.gnt1) begin
                if (bus.gnt0 && bus.gnt1) fail("dual_gnt");
                if (q.size() > 0) check("gnt_id", 32'(bus.gnt1), 32'(q[0].id));
                if (b2b_chk && last_done >= 0) check("gnt_b2b", cyc, last_done + 1);
                gnt_cyc  = cyc;
                busy_cnt = 0;
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                last_done = cyc;
                if (q.size() == 0) fail("unexpected_done");
                else begin
                    e = q.pop_front();
                    check("y", 32'(bus.y), 32'(e.y));
                    check("id", 32'(bus.id), 32'(e.id));
                    check("latency", cyc - gnt_cyc, e.amt + 1);
                    check("busy_len", busy_cnt, e.amt + 1);
                end
            end
        end
    end

    task automatic issue(input bit c, input logic [7:0] a, input logic [2:0] amt,
                         input bit lr, input logic [7:0] ey, input bit push);
        bit got = 1'b0;
        exp_t e;
        if (push) begin
            e.id = c; e.y = ey; e.amt = int'(amt);
            q.push_back(e);
        end
        @(negedge clk);
        if (c) begin bus.req1 = 1'b1; bus.a1 = a; bus.amt1 = amt; bus.lr1 = lr; end
        else   begin bus.req0 = 1'b1; bus.a0 = a; bus.amt0 = amt; bus.lr0 = lr; end
        for (int t = 0; t < 60 && !got; t++) begin
            @(negedge clk);
            if (c ? bus.gnt1 : bus.gnt0) got = 1'b1;
        end
        if (!got) fail("gnt_timeout");
        // Scramble the inputs once granted; captured values must not follow.
        if (c) begin bus.req1 = 1'b0; bus.a1 = ~a; bus.amt1 = ~amt; bus.lr1 = ~lr; end
        else   begin bus.req0 = 1'b0; bus.a0 = ~a; bus.amt0 = ~amt; bus.lr0 = ~lr; end
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge clk);
        if (q.size() != 0) begin
            fail("done_timeout");
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int ng;
        bus.req0 = 1'b0; bus.a0 = '0; bus.amt0 = '0; bus.lr0 = 1'b0;
        bus.req1 = 1'b0; bus.a1 = '0; bus.amt1 = '0; bus.lr1 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_gnt0", 32'(bus.gnt0), 0);
        check("rst_gnt1", 32'(bus.gnt1), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_id",   32'(bus.id), 0);
        check("rst_y",    32'(bus.y), 0);

        issue(1'b0, 8'b10010011, 3'd3, 1'b0, 8'b01110010, 1'b1);
        issue(1'b1, 8'b11100101, 3'd2, 1'b1, 8'b10010111, 1'b1);
        wait_idle();
        issue(1'b0, 8'b00111110, 3'd0, 1'b1, 8'b00111110, 1'b1);
        issue(1'b0, 8'b00111110, 3'd0, 1'b0, 8'b00111110, 1'b1);
        issue(1'b0, 8'b10000000, 3'd7, 1'b1, 8'b01000000, 1'b1);
        issue(1'b0, 8'b10000000, 3'd7, 1'b0, 8'b00000001, 1'b1);
        wait_idle();

        // Fairness: both clients request continuously from reset.
        reset = 1'b1;
        bus.req0 = 1'b1; bus.a0 = 8'b00000011; bus.amt0 = 3'd1; bus.lr0 = 1'b0;
        bus.req1 = 1'b1; bus.a1 = 8'b11110000; bus.amt1 = 3'd1; bus.lr1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.id  = i[0];
            e.y   = i[0] ? 8'b01111000 : 8'b10000001;
            e.amt = 1;
            q.push_back(e);
        end
        repeat (2) @(negedge clk);
        last_done = -1;
        b2b_chk = 1'b1;
        reset = 1'b0;
        ng = 0;
        for (int t = 0; t < 80 && ng < 4; t++) begin
            @(negedge clk);
            if (bus.gnt0 || bus.gnt1) ng++;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        if (ng < 4) fail("fair_gnt_count");
        wait_idle();
        b2b_chk = 1'b0;

        // Reset three cycles after a grant abandons the operation.
        issue(1'b0, 8'b10000000, 3'd7, 1'b0, 8'b00000001, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_y",    32'(bus.y), 0);
        check("midrst_done", 32'(bus.done), 0);
        repeat (12) @(negedge clk);
        issue(1'b1, 8'b00000001, 3'd1, 1'b1, 8'b00000010, 1'b1);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
